// File: rtl/coin_collector_if.sv
// coin_collector_if
//   Groups the customer-side strobes (coin, select, cancel), the downstream
//   transaction handshake and the status outputs of coin_collector.
//   slave  : the collector itself (consumes strobes, drives transaction/status).
//   master : whatever drives the strobes and the downstream acknowledge.
interface coin_collector_if;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       select_valid;
    logic [2:0] select_product;
    logic [3:0] select_qty;
    logic       cancel;
    logic       txn_ack;
    logic [3:0] txn_change;
    logic       txn_valid;
    logic [3:0] customer_money;
    logic [2:0] customer_request;
    logic [3:0] quantity_request;
    logic [3:0] credit;
    logic       coin_reject;
    logic       refund_valid;
    logic [3:0] refund_amount;

    modport slave (
        input  coin_valid, coin_code, select_valid, select_product, select_qty,
               cancel, txn_ack, txn_change,
        output txn_valid, customer_money, customer_request, quantity_request,
               credit, coin_reject, refund_valid, refund_amount
    );

    modport master (
        output coin_valid, coin_code, select_valid, select_product, select_qty,
               cancel, txn_ack, txn_change,
        input  txn_valid, customer_money, customer_request, quantity_request,
               credit, coin_reject, refund_valid, refund_amount
    );
endinterface

// File: rtl/coin_collector.sv
// coin_collector
//   Accumulates coin credit (saturating at 15 units by rejecting coins),
//   issues a purchase transaction downstream, and refunds leftover credit.
//   Optional feature macro: COIN_TIMEOUT_EN -- auto-refund after
//   TIMEOUT_CYCLES idle cycles in COLLECT. Default build has no counter.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : coin_collector_if.slave (strobes in, transaction/status out)
//
// state    | meaning
// IDLE     | no credit, waiting for the first coin
// COLLECT  | accumulating coins, waiting for select / cancel
// WAIT_ACK | transaction offered downstream, waiting for txn_ack
// REFUND   | one cycle: pulse refund of the remaining credit
module coin_collector #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    coin_collector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_ACK, REFUND} state_t;

    state_t     state_q, state_d;
    logic [3:0] coin_value;
    logic [4:0] coin_sum;
    logic       coin_accept, coin_rejected, take_txn, take_ack, take_refund;
    logic       timeout_hit;

    logic [3:0] credit_q, money_q, qty_q, refund_amount_q;
    logic [2:0] product_q;
    logic       txn_valid_q, coin_reject_q, refund_valid_q;

    always_comb begin
        case (bus.coin_code)
            2'b00:   coin_value = 4'd1;
            2'b01:   coin_value = 4'd2;
            2'b10:   coin_value = 4'd5;
            default: coin_value = 4'd10;
        endcase
    end

    // One extra bit so an overflowing coin is detected instead of wrapping.
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

`ifdef COIN_TIMEOUT_EN
    logic [7:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= 8'd0;
        else if (state_q != COLLECT || coin_accept)
            idle_cnt <= 8'd0;
        else
            idle_cnt <= idle_cnt + 8'd1;
    end

    assign timeout_hit = (state_q == COLLECT) &&
                         (idle_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        coin_accept   = 1'b0;
        coin_rejected = 1'b0;
        take_txn      = 1'b0;
        take_ack      = 1'b0;
        take_refund   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.coin_valid) begin
                    coin_accept = 1'b1;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.cancel) begin
                    coin_rejected = bus.coin_valid;
                    state_d       = REFUND;
                end else if (bus.select_valid && bus.select_qty != 4'd0) begin
                    coin_rejected = bus.coin_valid;
                    take_txn      = 1'b1;
                    state_d       = WAIT_ACK;
                end else begin
                    if (bus.coin_valid) begin
                        if (coin_sum <= 5'd15)
                            coin_accept = 1'b1;
                        else
                            coin_rejected = 1'b1;
                    end
                    // An accepted coin restarts the idle window instead.
                    if (timeout_hit && !coin_accept)
                        state_d = REFUND;
                end
            end
            WAIT_ACK: begin
                coin_rejected = bus.coin_valid;
                if (bus.txn_ack) begin
                    take_ack = 1'b1;
                    state_d  = (bus.txn_change != 4'd0) ? REFUND : IDLE;
                end
            end
            default: begin
                coin_rejected = bus.coin_valid;
                take_refund   = 1'b1;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q        <= 4'd0;
            money_q         <= 4'd0;
            product_q       <= 3'd0;
            qty_q           <= 4'd0;
            txn_valid_q     <= 1'b0;
            coin_reject_q   <= 1'b0;
            refund_valid_q  <= 1'b0;
            refund_amount_q <= 4'd0;
        end else begin
            coin_reject_q   <= coin_rejected;
            refund_valid_q  <= take_refund;
            refund_amount_q <= take_refund ? credit_q : 4'd0;

            if (coin_accept)
                credit_q <= (state_q == IDLE) ? coin_value : coin_sum[3:0];
            else if (take_ack)
                credit_q <= bus.txn_change;
            else if (take_refund)
                credit_q <= 4'd0;

            if (take_txn) begin
                txn_valid_q <= 1'b1;
                money_q     <= credit_q;
                product_q   <= bus.select_product;
                qty_q       <= bus.select_qty;
            end else if (take_ack) begin
                txn_valid_q <= 1'b0;
            end
        end
    end

    assign bus.txn_valid        = txn_valid_q;
    assign bus.customer_money   = money_q;
    assign bus.customer_request = product_q;
    assign bus.quantity_request = qty_q;
    assign bus.credit           = credit_q;
    assign bus.coin_reject      = coin_reject_q;
    assign bus.refund_valid     = refund_valid_q;
    assign bus.refund_amount    = refund_amount_q;
endmodule

// File: doc/coin_collector.md
COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 SHALL support parameter TIMEOUT_CYCLES, default 200, idle cycles in COLLECT before auto-refund (1..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port coin_valid  input  1  one-cycle coin-insert strobe.
REQ-006 SHALL have port coin_code  input  2  coin value code: 00=1, 01=2, 10=5, 11=10 units.
REQ-007 SHALL have port select_valid  input  1  one-cycle purchase-select strobe.
REQ-008 SHALL have port select_product  input  3  requested product id.
REQ-009 SHALL have port select_qty  input  4  requested quantity.
REQ-010 SHALL have port cancel  input  1  customer cancel/refund strobe.
REQ-011 SHALL have port txn_ack  input  1  downstream customer stage accepted the transaction.
REQ-012 SHALL have port txn_change  input  4  customer money remaining after the downstream transaction, valid with txn_ack.
REQ-013 SHALL have port txn_valid  output  1  transaction request to the downstream customer stage.
REQ-014 SHALL have port customer_money  output  4  credit offered with the transaction.
REQ-015 SHALL have port customer_request  output  3  latched product id.
REQ-016 SHALL have port quantity_request  output  4  latched quantity.
REQ-017 SHALL have port credit  output  4  current accumulated credit.
REQ-018 SHALL have port coin_reject  output  1  one-cycle pulse: coin returned unaccepted.
REQ-019 SHALL have port refund_valid  output  1  one-cycle refund pulse.
REQ-020 SHALL have port refund_amount  output  4  units refunded, valid with refund_valid.

Function
REQ-021 SHALL implement four states: IDLE, COLLECT, WAIT_ACK, REFUND.
REQ-022 SHALL in IDLE, on coin_valid, load credit with the coin value and move to COLLECT; select_valid and cancel in IDLE are ignored.
REQ-023 SHALL in COLLECT add the coin value to credit if the sum is at most 15; otherwise hold credit and pulse coin_reject in the next cycle (no wrap-around).
REQ-024 SHALL in COLLECT, on select_valid with select_qty not 0, latch product, quantity and credit onto the outputs, assert txn_valid in the next cycle, and move to WAIT_ACK; a select with select_qty 0 is ignored.
REQ-025 SHALL in COLLECT, on cancel, move to REFUND.
REQ-026 SHALL apply COLLECT priority cancel > select > coin; a coin arriving in the same cycle as an accepted cancel or select is rejected via coin_reject.
REQ-027 SHALL hold txn_valid and all transaction outputs stable in WAIT_ACK until txn_ack is sampled high.
REQ-028 SHALL on txn_ack load credit with txn_change, deassert txn_valid, and go to REFUND if txn_change is not 0, else to IDLE.
REQ-029 SHALL in WAIT_ACK and REFUND reject every coin and ignore cancel and select.
REQ-030 SHALL in REFUND pulse refund_valid for one cycle with refund_amount equal to credit, clear credit, and return to IDLE.
REQ-031 SHALL keep refund_amount 0 whenever refund_valid is 0.

Reset
REQ-032 SHALL on rst_n low immediately force state IDLE and credit 0, and clear txn_valid, customer_money, customer_request, quantity_request, coin_reject, refund_valid, refund_amount and the timeout counter.
REQ-033 SHALL discard any pending transaction when reset is asserted mid-operation, with no refund pulse.

Configuration
REQ-034 SHALL, with COIN_TIMEOUT_EN defined, count cycles in COLLECT, clear the count on each accepted coin, and move to REFUND when the count reaches TIMEOUT_CYCLES-1 with no select or cancel in that cycle.
REQ-035 SHALL, with COIN_TIMEOUT_EN undefined, contain no counter; COLLECT then exits only on select or cancel.

Verification
REQ-036 SHALL cover: coins 5,5,2 then select product 3 qty 2 -> txn_valid=1, customer_money=12, customer_request=3, quantity_request=2, held until ack.
REQ-037 SHALL cover: credit 12 then coin 10 -> coin_reject pulse, credit stays 12.
REQ-038 SHALL cover: ack with txn_change=4 -> refund_valid pulse with refund_amount=4, then IDLE with credit 0.
REQ-039 SHALL cover: coins 2,1 then cancel in the same cycle as a coin 5 -> coin_reject pulse, refund_amount=3.
REQ-040 SHALL cover: with COIN_TIMEOUT_EN defined and TIMEOUT_CYCLES=10, one coin 2 then idle -> refund_amount=2 after 10 cycles.
REQ-041 SHALL cover: rst_n low during WAIT_ACK -> all outputs 0 asynchronously, state IDLE.
